// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: one shift step per clock under an IDLE/SHIFT/DONE controller.
// Optional build macro SHIFT_SEQ_FAST_STEP_EN enables 4-bit steps while at least 4 remain.
module shift_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [4:0]       shamt,
   input  logic [WIDTH-1:0] inData,
   output logic [WIDTH-1:0] outData,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic [4:0]       step;
   logic [4:0]       cnt_rem;
   logic [WIDTH-1:0] acc_shifted;

   // Reserved op 2'b10 falls into the default arm and shifts left like SLL.
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] val,
                                                   input logic [1:0]       kind,
                                                   input logic [2:0]       amt);
      logic signed [WIDTH-1:0] sval;
      sval = $signed(val);
      case (kind)
         OP_SRL:  shift_step = val >> amt;
         OP_SRA:  shift_step = $unsigned(sval >>> amt);
         default: shift_step = val << amt;
      endcase
   endfunction

`ifdef SHIFT_SEQ_FAST_STEP_EN
   always_comb step = (cnt_q >= 5'd4) ? 5'd4 : 5'd1;
`else
   always_comb step = 5'd1;
`endif

   always_comb begin
      cnt_rem     = cnt_q - step;
      acc_shifted = shift_step(acc_q, op_q, step[2:0]);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = inData;
               cnt_d = shamt;
               op_d  = op;
               if (shamt == 5'd0) begin
                  state_d = S_DONE;
                  out_d   = inData;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            acc_d = acc_shifted;
            cnt_d = cnt_rem;
            if (cnt_rem == 5'd0) begin
               state_d = S_DONE;
               out_d   = acc_shifted;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Reset drops any in-flight operation and clears the published result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         out_q   <= out_d;
      end
   end

   assign outData = out_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: results, latency, busy/done handshake, dropped starts, reset.
module tb_shift_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] inData;
   logic [31:0] outData;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   shift_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .shamt   (shamt),
      .inData  (inData),
      .outData (outData),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles from the start-sampling edge until done is visible (counting that edge as 1).
   function automatic int lat(input int sa);
`ifdef SHIFT_SEQ_FAST_STEP_EN
      return (sa / 4) + (sa % 4) + 1;
`else
      return sa + 1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called one step after an edge at cycle n_in; waits (bounded) for done.
   task automatic track(input int n_in, output int n, output int busy_n, output bit seen);
      n      = n_in - 1;
      busy_n = 0;
      seen   = 1'b0;
      while (!seen && n < 64) begin
         n++;
         busy_n += int'(busy);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                         input logic [4:0] sa, input logic [31:0] exp);
      logic [31:0] prev;
      int n, busy_n;
      bit seen;
      prev = outData;
      @(negedge clk);
      start = 1'b1; op = o; shamt = sa; inData = d;
      @(posedge clk); #1;
      start = 1'b0; op = ~o; shamt = ~sa; inData = ~d;
      if (lat(int'(sa)) > 1) chk({tag, "_hold"}, outData, prev);
      track(1, n, busy_n, seen);
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_lat"}, 32'(n), 32'(lat(int'(sa))));
      chk({tag, "_res"}, outData, exp);
      chk({tag, "_busyn"}, 32'(busy_n), 32'(lat(int'(sa))));
      @(posedge clk); #1;
      chk({tag, "_done_fall"}, 32'(done), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n, busy_n, extra_done;
      bit seen;

      reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; inData = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out", outData, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_out", outData, 32'h0);

      run_op("sll70", 2'b00, 32'd70, 5'd2, 32'd280);
      run_op("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
      run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
      run_op("zero", 2'b11, 32'h1234_ABCD, 5'd0, 32'h1234_ABCD);
      run_op("resv", 2'b10, 32'd12, 5'd4, 32'd192);
      run_op("sra_pos", 2'b11, 32'h7FFF_0000, 5'd8, 32'h007F_FF00);
      run_op("sra_neg", 2'b11, 32'hF000_0080, 5'd5, 32'hFF80_0004);
      run_op("sll31", 2'b00, 32'd3, 5'd31, 32'h8000_0000);

      // Second start while busy must be dropped and leave the first result intact.
      @(negedge clk);
      start = 1'b1; op = 2'b00; shamt = 5'd3; inData = 32'd110;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'b01; shamt = 5'd1; inData = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0;
      track(2, n, busy_n, seen);
      chk("ign_seen", 32'(seen), 32'd1);
      chk("ign_lat", 32'(n), 32'(lat(3)));
      chk("ign_res", outData, 32'd880);
      extra_done = 0;
      repeat (6) begin
         @(posedge clk); #1;
         extra_done += int'(done);
      end
      chk("ign_extra_done", 32'(extra_done), 32'd0);
      chk("ign_busy", 32'(busy), 32'd0);
      chk("ign_res_hold", outData, 32'd880);

      // Asynchronous reset in the middle of a long SRL.
      @(negedge clk);
      start = 1'b1; op = 2'b01; shamt = 5'd20; inData = 32'hF000_0000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy_pre", 32'(busy), 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_out", outData, 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_post_busy", 32'(busy), 32'd0);
      chk("mid_post_out", outData, 32'h0);
      run_op("srl4", 2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
